// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencing controller: instruction field
// positions, the idle instruction word and the controller state encoding.
package corelet_pkg;

  localparam int unsigned INST_W     = 35;
  localparam int unsigned A_W        = 11;

  localparam int unsigned B_MODE     = 34;
  localparam int unsigned B_ACC      = 33;
  localparam int unsigned B_CEN_P    = 32;
  localparam int unsigned B_WEN_P    = 31;
  localparam int unsigned B_A_P      = 20;
  localparam int unsigned B_CEN_X    = 19;
  localparam int unsigned B_WEN_X    = 18;
  localparam int unsigned B_A_X      = 7;
  localparam int unsigned B_OFIFO_RD = 6;
  localparam int unsigned B_IFIFO_RD = 5;
  localparam int unsigned B_IFIFO_WR = 4;
  localparam int unsigned B_L0_RD    = 3;
  localparam int unsigned B_L0_WR    = 2;
  localparam int unsigned B_EXEC     = 1;
  localparam int unsigned B_LOAD     = 0;

  // Both SRAMs deselected and write-disabled; everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << B_CEN_P) |
                                            (INST_W'(1) << B_WEN_P) |
                                            (INST_W'(1) << B_CEN_X) |
                                            (INST_W'(1) << B_WEN_X);

  typedef enum logic [3:0] {
    S_IDLE, S_W_LOAD, S_K_LOAD, S_K_GAP, S_A_LOAD, S_EXEC, S_DRAIN, S_OUT, S_FIN
  } state_t;

endpackage

// File: rtl/corelet_ctrl_pipe_cnt.sv
// Transfer counter for read-then-write phases: counts issued reads and keeps a
// one-cycle delayed write strobe that stays pending until acknowledged.
module pipe_cnt #(
  parameter int unsigned len = 8,
  parameter int unsigned cw  = $clog2(len + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          issue,
  input  logic          ack,
  output logic [cw-1:0] cnt,
  output logic          pend,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      if (issue) cnt <= cnt + 1'b1;
      // A withheld write (no ack) stays pending; a new read re-arms it.
      pend <= issue | (pend & ~ack);
    end
  end

  assign last = (cnt == cw'(len));

endmodule

// File: rtl/corelet_ctrl.sv
// Layer sequencer: walks weight load, kernel load, activation load, execute,
// drain and output write-back for every kernel position, emitting inst each cycle.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned nij    = 36,
  parameter int unsigned kij    = 9,
  parameter int unsigned w_base = 1024,
  parameter int unsigned aw     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx
);

  localparam int unsigned WCW = $clog2(col + 1);
  localparam int unsigned NCW = $clog2(nij + 1);

  state_t              state, state_n;
  logic                mode_r, mode_n;
  logic [7:0]          g, g_n;
  logic [3:0]          k_n;
  logic [INST_W-1:0]   inst_n;
  logic                busy_n, done_n;

  logic [WCW-1:0] w_cnt;
  logic [NCW-1:0] a_cnt, o_cnt;
  logic w_pend, w_last, w_issue, w_ack, w_stall;
  logic a_pend, a_last, a_issue, a_ack;
  logic o_pend, o_last, o_issue, o_ack;
  logic [aw-1:0] w_addr, a_addr, p_addr;

  pipe_cnt #(.len(col)) u_w (
    .clk(clk), .reset(reset), .clr(state != S_W_LOAD), .issue(w_issue), .ack(w_ack),
    .cnt(w_cnt), .pend(w_pend), .last(w_last)
  );

  pipe_cnt #(.len(nij)) u_a (
    .clk(clk), .reset(reset), .clr(state != S_A_LOAD), .issue(a_issue), .ack(a_ack),
    .cnt(a_cnt), .pend(a_pend), .last(a_last)
  );

  pipe_cnt #(.len(nij)) u_o (
    .clk(clk), .reset(reset), .clr(state != S_OUT), .issue(o_issue), .ack(o_ack),
    .cnt(o_cnt), .pend(o_pend), .last(o_last)
  );

  assign w_addr  = aw'(w_base + 32'(kij_idx) * col + 32'(w_cnt));
  assign a_addr  = aw'(a_cnt);
  assign p_addr  = aw'(32'(kij_idx) * nij + 32'(o_cnt) - 32'd1);
  assign w_stall = l0_full & ~mode_r;

  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    k_n     = kij_idx;
    g_n     = '0;
    busy_n  = busy;
    done_n  = 1'b0;
    inst_n  = INST_IDLE;
    w_issue = 1'b0;
    w_ack   = 1'b0;
    a_issue = 1'b0;
    a_ack   = 1'b0;
    o_issue = 1'b0;
    o_ack   = 1'b0;

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          mode_n  = mode;
          k_n     = '0;
          busy_n  = 1'b1;
          state_n = S_W_LOAD;
        end
      end
      S_W_LOAD: begin
        // A stalled write freezes the whole pipeline, including the next read.
        if (!(w_pend && w_stall)) begin
          w_ack   = w_pend;
          w_issue = !w_last;
          if (w_issue) begin
            inst_n[B_CEN_X]          = 1'b0;
            inst_n[B_A_X +: A_W]     = A_W'(w_addr);
          end
          if (w_pend) begin
            if (mode_r) inst_n[B_IFIFO_WR] = 1'b1;
            else        inst_n[B_L0_WR]    = 1'b1;
          end
          if (w_last && w_pend) state_n = mode_r ? S_K_GAP : S_K_LOAD;
        end
      end
      S_K_LOAD: begin
        inst_n[B_L0_RD] = 1'b1;
        inst_n[B_LOAD]  = 1'b1;
        if (g == 8'(col - 1)) state_n = S_K_GAP;
        else                  g_n     = g + 8'd1;
      end
      S_K_GAP: begin
        if (g == 8'(row - 1)) state_n = S_A_LOAD;
        else                  g_n     = g + 8'd1;
      end
      S_A_LOAD: begin
        if (!(a_pend && l0_full)) begin
          a_ack   = a_pend;
          a_issue = !a_last;
          if (a_issue) begin
            inst_n[B_CEN_X]          = 1'b0;
            inst_n[B_A_X +: A_W]     = A_W'(a_addr);
          end
          if (a_pend) inst_n[B_L0_WR] = 1'b1;
          if (a_last && a_pend) state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        inst_n[B_L0_RD]    = 1'b1;
        inst_n[B_EXEC]     = 1'b1;
        inst_n[B_IFIFO_RD] = mode_r;
        if (g == 8'(nij - 1)) state_n = S_DRAIN;
        else                  g_n     = g + 8'd1;
      end
      S_DRAIN: begin
        if (g == 8'(row + col - 1)) state_n = S_OUT;
        else                        g_n     = g + 8'd1;
      end
      S_OUT: begin
        o_ack   = o_pend;
        o_issue = ofifo_valid && !o_last;
        if (o_issue) inst_n[B_OFIFO_RD] = 1'b1;
        if (o_pend) begin
          inst_n[B_CEN_P]          = 1'b0;
          inst_n[B_WEN_P]          = 1'b0;
          inst_n[B_A_P +: A_W]     = A_W'(p_addr);
        end
        if (o_last && o_pend) begin
          if (kij_idx == 4'(kij - 1)) begin
            state_n = S_FIN;
          end else begin
            k_n     = kij_idx + 4'd1;
            state_n = S_W_LOAD;
          end
        end
      end
      S_FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    inst_n[B_ACC]   = 1'b0;
    inst_n[B_WEN_X] = 1'b1;
    inst_n[B_MODE]  = mode_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mode_r  <= 1'b0;
      kij_idx <= '0;
      g       <= '0;
      inst    <= INST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_r  <= mode_n;
      kij_idx <= k_n;
      g       <= g_n;
      inst    <= inst_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: a negedge monitor tallies the instruction
// stream, and each scenario compares the tallies with hand-computed values.
module tb_corelet_ctrl;

  localparam int ROW = 8, COL = 8, NIJ = 36, KIJ = 9, WB = 1024;

  logic        clk = 1'b0;
  logic        reset, start, mode, l0_full, ofifo_valid;
  logic [34:0] inst;
  logic        busy, done;
  logic [3:0]  kij_idx;

  corelet_ctrl #(.row(ROW), .col(COL), .nij(NIJ), .kij(KIJ), .w_base(WB), .aw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .l0_full(l0_full),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int loads, l0wr, ifwr, ifrd, execs, pwr, rds, busy_cyc, done_cnt, done_k;
  int exp_paddr, exp_a, areads, wreads;
  int bad_paddr, bad_rdv, bad_wra, bad_a, bad_w, bad_mode, bad_ifx, bad_wen, bad_done;
  int first_rd_cyc, first_wr_cyc, busy_rise_cyc, k0_cyc, k1_cyc;
  int stall_left = 0;
  bit toggle = 1'b0, stall_arm = 1'b0, exp_mode = 1'b0;
  logic        prev_busy = 1'b0;
  logic [34:0] prev_inst = '0;

  task automatic clear_stats();
    loads = 0; l0wr = 0; ifwr = 0; ifrd = 0; execs = 0; pwr = 0; rds = 0;
    busy_cyc = 0; done_cnt = 0; done_k = -1; exp_paddr = 0; exp_a = 0; areads = 0; wreads = 0;
    bad_paddr = 0; bad_rdv = 0; bad_wra = 0; bad_a = 0; bad_w = 0; bad_mode = 0;
    bad_ifx = 0; bad_wen = 0; bad_done = 0;
    first_rd_cyc = -1; first_wr_cyc = -1; busy_rise_cyc = -1; k0_cyc = -1; k1_cyc = -1;
  endtask

  // Monitor: samples at negedge, also drives the l0_full burst and ofifo_valid toggling.
  initial begin
    int xa;
    clear_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) l0_full = 1'b0;
      end
      if (busy && !prev_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
      if (busy) busy_cyc++;
      if (busy && inst[34] !== exp_mode) bad_mode++;
      if (inst[18] !== 1'b1) bad_wen++;
      if (inst[0]) loads++;
      if (inst[2]) l0wr++;
      if (inst[4]) ifwr++;
      if (inst[5]) ifrd++;
      if (inst[1]) execs++;
      if (inst[5] !== (inst[1] & exp_mode)) bad_ifx++;
      if ((inst[2] || inst[4]) && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (inst[19] == 1'b0) begin
        xa = int'(inst[17:7]);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (xa >= WB) begin
          if (xa != WB + wreads) bad_w++;
          if (wreads == 0) k0_cyc = cyc;
          if (wreads == COL) k1_cyc = cyc;
          wreads++;
        end else begin
          if (xa != exp_a) bad_a++;
          exp_a = (exp_a + 1) % NIJ;
          areads++;
          if (stall_arm && xa == 10) begin
            stall_arm  = 1'b0;
            l0_full    = 1'b1;
            stall_left = 3;
          end
        end
      end
      if (inst[32] == 1'b0 && inst[31] == 1'b0) begin
        pwr++;
        if (int'(inst[30:20]) != exp_paddr) bad_paddr++;
        exp_paddr++;
        if (!prev_inst[6]) bad_wra++;
      end else if (prev_inst[6]) begin
        bad_wra++;
      end
      if (inst[6]) begin
        rds++;
        if (!ofifo_valid) bad_rdv++;
      end
      if (done) begin
        done_cnt++;
        done_k = int'(kij_idx);
        if (busy || !prev_busy) bad_done++;
      end
      prev_inst = inst;
      prev_busy = busy;
      if (toggle) ofifo_valid = ~ofifo_valid;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_layer(input logic m);
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      step();
      n++;
    end
    chk(tag, done_cnt, 1);
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; mode = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b1;
    repeat (3) step();
    chk("rst_inst", inst, 35'h1800C0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_kij", kij_idx, 0);
    reset = 1'b0;
    step();

    // WS layer, OFIFO always valid
    clear_stats();
    start_layer(1'b0);
    wait_done("ws_done", 3000);
    chk("ws_pwr", pwr, 324);
    chk("ws_paddr_order", bad_paddr, 0);
    chk("ws_last_paddr", exp_paddr, 324);
    chk("ws_loads", loads, 72);
    chk("ws_l0wr", l0wr, 9 * (COL + NIJ));
    chk("ws_ififowr", ifwr, 0);
    chk("ws_done_kij", done_k, 8);
    chk("ws_busy_done", bad_done, 0);
    chk("ws_busy_cycles", busy_cyc, 1360);
    chk("ws_rd_lat", first_rd_cyc - busy_rise_cyc, 1);
    chk("ws_wr_lat", first_wr_cyc - first_rd_cyc, 1);
    chk("ws_kernel_period", k1_cyc - k0_cyc, 151);
    chk("ws_worder", bad_w, 0);
    chk("ws_wreads", wreads, 72);
    chk("ws_aorder", bad_a, 0);
    chk("ws_wen_x", bad_wen, 0);
    chk("ws_wr_after_rd", bad_wra, 0);

    // WS layer with a 3-cycle l0_full burst inside the first activation load
    clear_stats();
    stall_arm = 1'b1;
    start_layer(1'b0);
    wait_done("stall_done", 3000);
    chk("stall_l0wr", l0wr, 9 * (COL + NIJ));
    chk("stall_aorder", bad_a, 0);
    chk("stall_areads", areads, 324);
    chk("stall_busy_cycles", busy_cyc, 1363);
    chk("stall_consumed", stall_arm, 0);

    // WS layer with ofifo_valid toggling every cycle
    clear_stats();
    toggle = 1'b1;
    start_layer(1'b0);
    wait_done("tog_done", 6000);
    toggle = 1'b0;
    ofifo_valid = 1'b1;
    chk("tog_rd_when_valid", bad_rdv, 0);
    chk("tog_rds", rds, 324);
    chk("tog_pwr", pwr, 324);
    chk("tog_paddr_order", bad_paddr, 0);
    chk("tog_wr_after_rd", bad_wra, 0);

    // OS layer
    exp_mode = 1'b1;
    clear_stats();
    start_layer(1'b1);
    wait_done("os_done", 3000);
    chk("os_loads", loads, 0);
    chk("os_ififowr", ifwr, 72);
    chk("os_worder", bad_w, 0);
    chk("os_ififo_rd_exec", bad_ifx, 0);
    chk("os_ififo_rd", ifrd, 324);
    chk("os_execs", execs, 324);
    chk("os_mode_bit", bad_mode, 0);
    chk("os_l0wr", l0wr, 324);
    chk("os_busy_cycles", busy_cyc, 1288);
    chk("os_wen_x", bad_wen, 0);
    exp_mode = 1'b0;

    // Reset in EXEC of kernel 4, then restart with a stray start while busy
    clear_stats();
    start_layer(1'b0);
    n = 0;
    while (!(kij_idx == 4'd4 && inst[1] == 1'b1) && n < 2000) begin
      step();
      n++;
    end
    chk("rst_reach_exec4", (kij_idx == 4'd4 && inst[1] == 1'b1), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_inst", inst, 35'h1800C0000);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_kij", kij_idx, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("mid_rst_no_done", done_cnt, 0);

    clear_stats();
    start_layer(1'b0);
    chk("restart_kij", kij_idx, 0);
    repeat (30) step();
    start = 1'b1;
    mode  = 1'b1;
    step();
    start = 1'b0;
    mode  = 1'b0;
    wait_done("restart_done", 3000);
    chk("restart_worder", bad_w, 0);
    chk("restart_wreads", wreads, 72);
    chk("restart_mode_bit", bad_mode, 0);
    chk("restart_loads", loads, 72);
    chk("restart_busy_cycles", busy_cyc, 1360);
    chk("restart_pwr", pwr, 324);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
